// File: rtl/minibus_decoder_tmo_pkg.sv
// Shared types and helpers for the minibus decoder with decode-error and timeout responses.
// States, error codes and the saturating error-counter increment live here.
package minibus_decoder_tmo_pkg;

    typedef enum logic [2:0] {
        IDLE,
        BUSY,
        RESP,
        DERR,
        TERR
    } minibus_dec_state_e;

    typedef enum logic [1:0] {
        OK      = 2'd0,
        SLV_ERR = 2'd1,
        DEC_ERR = 2'd2,
        TMO_ERR = 2'd3
    } minibus_errcode_e;

    localparam int ERR_CNT_W = 16;

    function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] v);
        return (v == {ERR_CNT_W{1'b1}}) ? v : v + ERR_CNT_W'(1);
    endfunction

endpackage

// File: rtl/minibus_decoder_tmo_if.sv
// Minibus connection bundle: core-side request/response plus the broadcast slave-side bus.
// The decoder uses the slave modport; whatever drives it (core and slaves) uses master.
interface minibus_decoder_tmo_if #(
    parameter int SLAVE_COUNT = 4,
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32
);
    logic                              m_req_valid;
    logic [ADDR_W-1:0]                 m_req_addr;
    logic                              m_req_wen;
    logic [DATA_W-1:0]                 m_req_wdata;
    logic [DATA_W/8-1:0]               m_req_wstrb;
    logic                              m_res_ready;
    logic [DATA_W-1:0]                 m_res_rdata;
    logic                              m_res_err;
    logic [1:0]                        m_res_errcode;

    logic [SLAVE_COUNT-1:0]            s_sel;
    logic [ADDR_W-1:0]                 s_req_addr;
    logic                              s_req_wen;
    logic [DATA_W-1:0]                 s_req_wdata;
    logic [DATA_W/8-1:0]               s_req_wstrb;
    logic [SLAVE_COUNT-1:0]            s_res_ready;
    logic [SLAVE_COUNT-1:0][DATA_W-1:0] s_res_rdata;
    logic [SLAVE_COUNT-1:0]            s_res_err;

    modport slave (
        input  m_req_valid, m_req_addr, m_req_wen, m_req_wdata, m_req_wstrb,
        output m_res_ready, m_res_rdata, m_res_err, m_res_errcode,
        output s_sel, s_req_addr, s_req_wen, s_req_wdata, s_req_wstrb,
        input  s_res_ready, s_res_rdata, s_res_err
    );

    modport master (
        output m_req_valid, m_req_addr, m_req_wen, m_req_wdata, m_req_wstrb,
        input  m_res_ready, m_res_rdata, m_res_err, m_res_errcode,
        input  s_sel, s_req_addr, s_req_wen, s_req_wdata, s_req_wstrb,
        output s_res_ready, s_res_rdata, s_res_err
    );

endinterface

// File: rtl/minibus_decoder_tmo_addr_match.sv
// Combinational address map compare with lowest-index priority.
// A region with start >= end can never match, which is how regions are disabled.
module minibus_decoder_tmo_addr_match #(
    parameter int SLAVE_COUNT = 4,
    parameter int ADDR_W      = 32,
    parameter int IDX_W       = 2
) (
    input  logic [ADDR_W-1:0]                   addr,
    input  logic [SLAVE_COUNT-1:0][ADDR_W-1:0]  map_start,
    input  logic [SLAVE_COUNT-1:0][ADDR_W-1:0]  map_end,
    output logic                                hit,
    output logic [IDX_W-1:0]                    idx
);

    logic [SLAVE_COUNT-1:0] hit_vec;

    generate
        for (genvar gi = 0; gi < SLAVE_COUNT; gi++) begin : g_cmp
            assign hit_vec[gi] = (addr >= map_start[gi]) && (addr < map_end[gi]);
        end
    endgenerate

    // Scan from the top so the lowest matching index is the one left standing.
    always_comb begin
        hit = |hit_vec;
        idx = '0;
        for (int k = SLAVE_COUNT - 1; k >= 0; k--) begin
            if (hit_vec[k]) begin
                idx = IDX_W'(k);
            end
        end
    end

endmodule

// File: rtl/minibus_decoder_tmo.sv
// Single-master minibus decoder: latches each request, routes it to one slave, and answers
// unmapped addresses and stalled slaves itself with error responses and error statistics.
module minibus_decoder_tmo
    import minibus_decoder_tmo_pkg::*;
#(
    parameter int SLAVE_COUNT    = 4,
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                                clk,
    input  logic                                rst,
    minibus_decoder_tmo_if.slave                bus,
    input  logic [SLAVE_COUNT-1:0][ADDR_W-1:0]  map_start,
    input  logic [SLAVE_COUNT-1:0][ADDR_W-1:0]  map_end,
    output logic [ERR_CNT_W-1:0]                err_cnt,
    output logic [ADDR_W-1:0]                   err_addr
);

    localparam int IDX_W   = (SLAVE_COUNT > 1) ? $clog2(SLAVE_COUNT) : 1;
    localparam int STRB_W  = DATA_W / 8;
    localparam int TIMER_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    minibus_dec_state_e     state_reg, state_next;
    logic [IDX_W-1:0]       idx_reg;
    logic [TIMER_W-1:0]     timer_reg;
    logic [ADDR_W-1:0]      req_addr_reg;
    logic                   req_wen_reg;
    logic [DATA_W-1:0]      req_wdata_reg;
    logic [STRB_W-1:0]      req_wstrb_reg;
    logic [DATA_W-1:0]      resp_rdata_reg;
    logic                   resp_err_reg;
    logic                   res_ready_reg;
    logic [DATA_W-1:0]      res_rdata_reg;
    logic                   res_err_reg;
    minibus_errcode_e       res_code_reg;
    logic [ERR_CNT_W-1:0]   err_cnt_reg;
    logic [ADDR_W-1:0]      err_addr_reg;

    logic                   match_hit;
    logic [IDX_W-1:0]       match_idx;
    logic                   accept;
    logic                   sel_ready;
    logic                   tmo_hit;
    logic                   cpl_valid;
    logic                   cpl_err;
    minibus_errcode_e       cpl_code;
    logic [DATA_W-1:0]      cpl_rdata;

    minibus_decoder_tmo_addr_match #(
        .SLAVE_COUNT (SLAVE_COUNT),
        .ADDR_W      (ADDR_W),
        .IDX_W       (IDX_W)
    ) u_addr_match (
        .addr      (bus.m_req_addr),
        .map_start (map_start),
        .map_end   (map_end),
        .hit       (match_hit),
        .idx       (match_idx)
    );

    assign sel_ready = bus.s_res_ready[idx_reg];

    generate
        if (TIMEOUT_CYCLES > 0) begin : g_tmo
            assign tmo_hit = (timer_reg == TIMER_W'(TIMEOUT_CYCLES - 1));
        end else begin : g_no_tmo
            assign tmo_hit = 1'b0;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // The cycle carrying m_res_ready still sees the old valid, so acceptance waits one cycle.
    always_comb begin
        state_next = state_reg;
        accept     = 1'b0;
        cpl_valid  = 1'b0;
        cpl_err    = 1'b0;
        cpl_code   = OK;
        cpl_rdata  = '0;
        unique case (state_reg)
            IDLE: begin
                if (bus.m_req_valid && !res_ready_reg) begin
                    accept     = 1'b1;
                    state_next = match_hit ? BUSY : DERR;
                end
            end
            BUSY: begin
                if (sel_ready) begin
                    state_next = RESP;
                end else if (tmo_hit) begin
                    state_next = TERR;
                end
            end
            RESP: begin
                cpl_valid  = 1'b1;
                cpl_err    = resp_err_reg;
                cpl_code   = resp_err_reg ? SLV_ERR : OK;
                cpl_rdata  = resp_rdata_reg;
                state_next = IDLE;
            end
            DERR: begin
                cpl_valid  = 1'b1;
                cpl_err    = 1'b1;
                cpl_code   = DEC_ERR;
                state_next = IDLE;
            end
            TERR: begin
                cpl_valid  = 1'b1;
                cpl_err    = 1'b1;
                cpl_code   = TMO_ERR;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx_reg        <= '0;
            timer_reg      <= '0;
            req_addr_reg   <= '0;
            req_wen_reg    <= 1'b0;
            req_wdata_reg  <= '0;
            req_wstrb_reg  <= '0;
            resp_rdata_reg <= '0;
            resp_err_reg   <= 1'b0;
            res_ready_reg  <= 1'b0;
            res_rdata_reg  <= '0;
            res_err_reg    <= 1'b0;
            res_code_reg   <= OK;
            err_cnt_reg    <= '0;
            err_addr_reg   <= '0;
        end else begin
            if (accept) begin
                idx_reg       <= match_idx;
                req_addr_reg  <= bus.m_req_addr;
                req_wen_reg   <= bus.m_req_wen;
                req_wdata_reg <= bus.m_req_wdata;
                req_wstrb_reg <= bus.m_req_wstrb;
            end
            // Held at zero outside BUSY so every transaction starts counting from zero.
            timer_reg <= (state_reg == BUSY) ? timer_reg + TIMER_W'(1) : '0;
            if (state_reg == BUSY && sel_ready) begin
                resp_rdata_reg <= bus.s_res_rdata[idx_reg];
                resp_err_reg   <= bus.s_res_err[idx_reg];
            end
            res_ready_reg <= cpl_valid;
            res_rdata_reg <= cpl_rdata;
            res_err_reg   <= cpl_err;
            res_code_reg  <= cpl_code;
            if (cpl_valid && cpl_err) begin
                err_cnt_reg  <= sat_inc(err_cnt_reg);
                err_addr_reg <= req_addr_reg;
            end
        end
    end

    generate
        for (genvar gi = 0; gi < SLAVE_COUNT; gi++) begin : g_sel
            assign bus.s_sel[gi] = (state_reg == BUSY) && (idx_reg == IDX_W'(gi));
        end
    endgenerate

    assign bus.s_req_addr    = req_addr_reg;
    assign bus.s_req_wen     = req_wen_reg;
    assign bus.s_req_wdata   = req_wdata_reg;
    assign bus.s_req_wstrb   = req_wstrb_reg;
    assign bus.m_res_ready   = res_ready_reg;
    assign bus.m_res_rdata   = res_rdata_reg;
    assign bus.m_res_err     = res_err_reg;
    assign bus.m_res_errcode = res_code_reg;
    assign err_cnt           = err_cnt_reg;
    assign err_addr          = err_addr_reg;

endmodule

// File: tb/tb_minibus_decoder_tmo.sv
// Directed and randomized transactions for minibus_decoder_tmo, checked against a
// transaction-level model of routing, latency, responses and error statistics.
module tb_minibus_decoder_tmo;
    import minibus_decoder_tmo_pkg::*;

    localparam int SC  = 4;
    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int TMO = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    minibus_decoder_tmo_if #(.SLAVE_COUNT(SC), .ADDR_W(AW), .DATA_W(DW)) bus ();

    logic [SC-1:0][AW-1:0] map_start;
    logic [SC-1:0][AW-1:0] map_end;
    logic [15:0]           err_cnt;
    logic [AW-1:0]         err_addr;

    minibus_decoder_tmo #(
        .SLAVE_COUNT    (SC),
        .ADDR_W         (AW),
        .DATA_W         (DW),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .map_start (map_start),
        .map_end   (map_end),
        .err_cnt   (err_cnt),
        .err_addr  (err_addr)
    );

    int          n_checks = 0;
    int          n_pass   = 0;
    int          n_txn    = 0;
    int          model_err_cnt = 0;
    logic [AW-1:0] model_err_addr = '0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Target slave by the map rules: first enabled region containing the address, else -1.
    function automatic int ref_target(input logic [AW-1:0] a);
        for (int k = 0; k < SC; k++) begin
            if (map_start[k] < map_end[k] && a >= map_start[k] && a < map_end[k]) return k;
        end
        return -1;
    endfunction

    task automatic set_map(input int k, input logic [AW-1:0] s, input logic [AW-1:0] e);
        map_start[k] = s;
        map_end[k]   = e;
    endtask

    // Called just after a rising edge; w = BUSY cycles the slave waits before ready.
    task automatic txn(input logic [AW-1:0] addr, input logic wen, input logic [DW-1:0] wdata,
                       input logic [3:0] wstrb, input int w, input logic [DW-1:0] rdata,
                       input logic serr, input bit hold, input bit wobble);
        int            tgt, exp_lat, sel_len, cyc;
        logic          exp_err;
        logic [1:0]    exp_code;
        logic [DW-1:0] exp_rdata;
        logic [SC-1:0] exp_sel, tmask;
        bit            done;
        tgt = ref_target(addr);
        if (tgt < 0) begin
            exp_lat = 2; sel_len = 0; exp_err = 1'b1; exp_code = 2'd2; exp_rdata = '0;
        end else if (w < TMO) begin
            exp_lat = w + 3; sel_len = w + 1; exp_err = serr; exp_code = serr ? 2'd1 : 2'd0;
            exp_rdata = rdata;
        end else begin
            exp_lat = TMO + 2; sel_len = TMO; exp_err = 1'b1; exp_code = 2'd3; exp_rdata = '0;
        end
        if (exp_err) begin
            if (model_err_cnt < 16'hFFFF) model_err_cnt++;
            model_err_addr = addr;
        end
        tmask = (tgt >= 0) ? (SC'(1) << tgt) : '0;
        bus.m_req_valid = 1'b1;
        bus.m_req_addr  = addr;
        bus.m_req_wen   = wen;
        bus.m_req_wdata = wdata;
        bus.m_req_wstrb = wstrb;
        cyc  = 0;
        done = 0;
        while (!done && cyc < 40) begin
            @(negedge clk);
            exp_sel = (tgt >= 0 && cyc >= 1 && cyc <= sel_len) ? tmask : '0;
            check("s_sel", bus.s_sel, exp_sel);
            if (exp_sel != '0) begin
                check("s_req_addr", bus.s_req_addr, addr);
                check("s_req_wen", bus.s_req_wen, wen);
                check("s_req_wdata", bus.s_req_wdata, wdata);
                check("s_req_wstrb", bus.s_req_wstrb, wstrb);
            end
            bus.s_res_ready = SC'($urandom) & ~tmask;
            bus.s_res_err   = SC'($urandom);
            for (int k = 0; k < SC; k++) bus.s_res_rdata[k] = $urandom;
            if (tgt >= 0 && w < TMO && cyc == w + 1) begin
                bus.s_res_ready[tgt] = 1'b1;
                bus.s_res_rdata[tgt] = rdata;
                bus.s_res_err[tgt]   = serr;
            end
            if (bus.m_res_ready) begin
                check("latency", cyc, exp_lat);
                check("m_res_rdata", bus.m_res_rdata, exp_rdata);
                check("m_res_err", bus.m_res_err, exp_err);
                check("m_res_errcode", bus.m_res_errcode, exp_code);
                check("err_cnt", err_cnt, model_err_cnt);
                check("err_addr", err_addr, model_err_addr);
                done = 1;
            end else begin
                if (wobble && cyc == 2) begin
                    bus.m_req_addr  = addr ^ 32'h0000_0F00;
                    bus.m_req_wdata = ~wdata;
                    bus.m_req_wstrb = ~wstrb;
                end
                @(posedge clk); #1;
                cyc++;
            end
        end
        if (!done) check("resp_wait", cyc, exp_lat);
        $display("txn %0d addr=0x%0h wen=%0d tgt=%0d wait=%0d lat=%0d code=%0d", n_txn, addr, wen,
                 tgt, w, cyc, bus.m_res_errcode);
        n_txn++;
        @(posedge clk); #1;
        bus.s_res_ready = '0;
        if (!hold) begin
            bus.m_req_valid = 1'b0;
            @(negedge clk);
            check("ready_pulse", bus.m_res_ready, 1'b0);
            @(posedge clk); #1;
        end
    endtask

    initial begin
        rst = 1'b1;
        bus.m_req_valid = 1'b0;
        bus.m_req_addr  = '0;
        bus.m_req_wen   = 1'b0;
        bus.m_req_wdata = '0;
        bus.m_req_wstrb = '0;
        bus.s_res_ready = '0;
        bus.s_res_rdata = '0;
        bus.s_res_err   = '0;
        map_start = '0;
        map_end   = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_s_sel", bus.s_sel, '0);
        check("rst_ready", bus.m_res_ready, 1'b0);
        check("rst_err", bus.m_res_err, 1'b0);
        check("rst_code", bus.m_res_errcode, 2'd0);
        check("rst_rdata", bus.m_res_rdata, '0);
        check("rst_s_req_addr", bus.s_req_addr, '0);
        check("rst_err_cnt", err_cnt, '0);
        check("rst_err_addr", err_addr, '0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Basic hit, unmapped miss, timeout, slave error, ready on the last allowed cycle.
        set_map(0, 32'h0000, 32'h1000);
        set_map(1, 32'h1000, 32'h2000);
        txn(32'h1004, 1'b0, 32'h0, 4'h0, 2, 32'hDEADBEEF, 1'b0, 0, 0);
        txn(32'h8000, 1'b0, 32'h0, 4'h0, 0, 32'h0, 1'b0, 0, 0);
        txn(32'h0040, 1'b0, 32'h0, 4'h0, 10, 32'h1234, 1'b0, 0, 0);
        txn(32'h1100, 1'b1, 32'hCAFE0001, 4'hF, 0, 32'h5555, 1'b1, 0, 0);
        txn(32'h0ffc, 1'b0, 32'h0, 4'h0, TMO - 1, 32'hA5A5A5A5, 1'b0, 0, 0);
        txn(32'h2000, 1'b0, 32'h0, 4'h0, 0, 32'h0, 1'b0, 0, 0);

        // Overlap priority and a disabled region.
        set_map(0, 32'h0000, 32'h2000);
        txn(32'h1800, 1'b0, 32'h0, 4'h0, 1, 32'h0BADF00D, 1'b0, 0, 0);
        set_map(1, 32'h1000, 32'h1000);
        txn(32'h1000, 1'b0, 32'h0, 4'h0, 0, 32'h11112222, 1'b0, 0, 0);

        // Back-to-back writes with the request wobbling while BUSY.
        set_map(0, 32'h0000, 32'h1000);
        set_map(1, 32'h1000, 32'h2000);
        txn(32'h0010, 1'b1, 32'h01020304, 4'b0011, 2, 32'h0, 1'b0, 1, 1);
        txn(32'h1010, 1'b1, 32'hF0E0D0C0, 4'b1100, 3, 32'h0, 1'b0, 0, 1);

        // Reset while BUSY: select drops, no response, statistics cleared.
        bus.m_req_valid = 1'b1;
        bus.m_req_addr  = 32'h0020;
        bus.m_req_wen   = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        @(negedge clk);
        check("busy_before_rst", bus.s_sel, 4'b0001);
        rst = 1'b1;
        bus.m_req_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        model_err_cnt  = 0;
        model_err_addr = '0;
        @(negedge clk);
        check("rst_busy_s_sel", bus.s_sel, '0);
        check("rst_busy_ready", bus.m_res_ready, 1'b0);
        check("rst_busy_err_cnt", err_cnt, '0);
        check("rst_busy_err_addr", err_addr, '0);
        repeat (3) begin
            @(negedge clk);
            check("rst_busy_no_resp", bus.m_res_ready, 1'b0);
        end
        @(posedge clk); #1;

        // Randomized maps and transactions.
        for (int r = 0; r < 60; r++) begin
            if (r % 10 == 0) begin
                for (int k = 0; k < SC; k++) begin
                    logic [AW-1:0] s;
                    s = AW'($urandom_range(0, 48)) << 8;
                    set_map(k, s, ($urandom_range(0, 5) == 0) ? (s >> 1)
                                  : s + (AW'($urandom_range(0, 24)) << 8));
                end
            end
            txn(AW'($urandom_range(0, 16'h3FFF)), 1'($urandom), $urandom, 4'($urandom),
                $urandom_range(0, TMO + 1), $urandom, 1'($urandom_range(0, 3) == 0),
                (r != 59) && ($urandom_range(0, 2) == 0), 1'($urandom));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
